// File: rtl/cordic_pkg.sv
// Purpose: shared types and constants for the CORDIC sharing controller.
// Latency: n/a (declarations only).
// Backpressure: n/a. Contents: W_DEF operand width, state_t FSM states, clog2 ID-width helper.
package cordic_pkg;

  localparam int W_DEF = 13;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Width of an index able to address n items; never less than 1 bit.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/cordic_share_ctrl_if.sv
// Purpose: bundles requester, CORDIC core and response signals of the sharing controller.
// Latency: n/a (wires only).
// Backpressure: rsp_valid/rsp_ready handshake; req is a level held until gnt.
// Ports: master = controller side, slave = requesters/core/consumer side.
interface cordic_share_ctrl_if import cordic_pkg::*; #(
  parameter int N_REQ = 4,
  parameter int W     = W_DEF
);
  localparam int IW = clog2(N_REQ);

  logic [N_REQ-1:0]   req;
  logic [N_REQ*W-1:0] req_i;
  logic [N_REQ*W-1:0] req_q;
  logic [N_REQ-1:0]   gnt;
  logic [W-1:0]       core_i;
  logic [W-1:0]       core_q;
  logic               core_enable;
  logic               core_ready;
  logic [W-1:0]       core_pm;
  logic [W-1:0]       core_am;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IW-1:0]      rsp_id;
  logic [W-1:0]       rsp_pm;
  logic [W-1:0]       rsp_am;
  logic               rsp_err;
  logic               busy;

  modport master (
    input  req, req_i, req_q, core_ready, core_pm, core_am, rsp_ready,
    output gnt, core_i, core_q, core_enable, rsp_valid, rsp_id, rsp_pm, rsp_am, rsp_err, busy
  );

  modport slave (
    output req, req_i, req_q, core_ready, core_pm, core_am, rsp_ready,
    input  gnt, core_i, core_q, core_enable, rsp_valid, rsp_id, rsp_pm, rsp_am, rsp_err, busy
  );

endinterface

// File: rtl/cordic_share_ctrl_rr_arbiter.sv
// Purpose: round-robin pick of the first set req bit searching upward from rr_ptr, wrapping.
// Latency: combinational.
// Backpressure: none; the caller decides when the pick is consumed.
// Ports: req, rr_ptr in; found, one-hot pick and binary pick_idx out.
module rr_arbiter import cordic_pkg::*; #(
  parameter int N_REQ = 4,
  parameter int IW    = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    rr_ptr,
  output logic             found,
  output logic [N_REQ-1:0] pick,
  output logic [IW-1:0]    pick_idx
);

  always_comb begin
    logic [IW-1:0] j;
    found    = 1'b0;
    pick     = '0;
    pick_idx = '0;
    j        = '0;
    for (int k = 0; k < N_REQ; k++) begin
      j = IW'((int'(rr_ptr) + k) % N_REQ);
      if (!found && req[j]) begin
        found    = 1'b1;
        pick[j]  = 1'b1;
        pick_idx = j;
      end
    end
  end

endmodule

// File: rtl/cordic_share_ctrl.sv
// Purpose: round-robin sharing of one iterative CORDIC core among N_REQ requesters.
// Latency: req->gnt/core_enable 1 cycle; core_ready->rsp_valid 1 cycle; timeout at TIMEOUT+1 after enable.
// Backpressure: response held until rsp_ready; no new grant until the response is taken.
// Ports: CLK1, RST_n (async active-low), bus (cordic_share_ctrl_if.master).
module cordic_share_ctrl import cordic_pkg::*; #(
  parameter int N_REQ   = 4,
  parameter int W       = W_DEF,
  parameter int TIMEOUT = 63
) (
  input logic                 CLK1,
  input logic                 RST_n,
  cordic_share_ctrl_if.master bus
);
  localparam int         IW     = clog2(N_REQ);
  localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

  state_t             state, state_nxt;
  logic [IW-1:0]      rr_ptr, id, ptr_nxt;
  logic [7:0]         cnt, cnt_inc;
  logic [W-1:0]       op_i, op_q, res_pm, res_am;
  logic               res_err;
  logic               arb_found;
  logic [N_REQ-1:0]   arb_pick;
  logic [IW-1:0]      arb_idx;
  logic [W-1:0]       sel_i, sel_q;
  logic               ready_hit, timeout_hit;

  rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_arb (
    .req      (bus.req),
    .rr_ptr   (rr_ptr),
    .found    (arb_found),
    .pick     (arb_pick),
    .pick_idx (arb_idx)
  );

  // AND-OR operand mux driven by the one-hot pick.
  always_comb begin
    sel_i = '0;
    sel_q = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (arb_pick[k]) begin
        sel_i = sel_i | bus.req_i[k*W +: W];
        sel_q = sel_q | bus.req_q[k*W +: W];
      end
    end
  end

  assign cnt_inc = cnt + 8'd1;
  assign ptr_nxt = (id == IW'(N_REQ - 1)) ? '0 : id + IW'(1);

  always_ff @(posedge CLK1 or negedge RST_n) begin
    if (!RST_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    ready_hit       = 1'b0;
    timeout_hit     = 1'b0;
    bus.gnt         = '0;
    bus.core_enable = 1'b0;
    bus.rsp_valid   = 1'b0;
    bus.busy        = (state != IDLE);
    case (state)
      IDLE: if (arb_found) state_nxt = START;
      START: begin
        bus.gnt         = N_REQ'(1) << id;
        bus.core_enable = 1'b1;
        state_nxt       = WAIT;
      end
      WAIT: begin
        // A ready arriving on the final timeout cycle still counts as a result.
        if (bus.core_ready) begin
          ready_hit = 1'b1;
          state_nxt = RESP;
        end else if (cnt_inc == TO_CNT) begin
          timeout_hit = 1'b1;
          state_nxt   = RESP;
        end
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK1 or negedge RST_n) begin
    if (!RST_n) begin
      rr_ptr  <= '0;
      id      <= '0;
      cnt     <= '0;
      op_i    <= '0;
      op_q    <= '0;
      res_pm  <= '0;
      res_am  <= '0;
      res_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_found) begin
            id   <= arb_idx;
            op_i <= sel_i;
            op_q <= sel_q;
          end
        end
        START: begin
          rr_ptr <= ptr_nxt;
          cnt    <= '0;
        end
        WAIT: begin
          cnt <= cnt_inc;
          if (ready_hit) begin
            res_pm  <= bus.core_pm;
            res_am  <= bus.core_am;
            res_err <= 1'b0;
          end else if (timeout_hit) begin
            res_pm  <= '0;
            res_am  <= '0;
            res_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.core_i  = op_i;
  assign bus.core_q  = op_q;
  assign bus.rsp_id  = id;
  assign bus.rsp_pm  = res_pm;
  assign bus.rsp_am  = res_am;
  assign bus.rsp_err = res_err;

endmodule

// File: tb/tb_cordic_share_ctrl.sv
module tb_cordic_share_ctrl;
  import cordic_pkg::*;

  localparam int N  = 4;
  localparam int WW = 13;
  localparam int TO = 63;

  logic CLK1  = 1'b0;
  logic RST_n = 1'b0;

  cordic_share_ctrl_if #(.N_REQ(N), .W(WW)) bus ();

  cordic_share_ctrl #(.N_REQ(N), .W(WW), .TIMEOUT(TO)) dut (
    .CLK1  (CLK1),
    .RST_n (RST_n),
    .bus   (bus)
  );

  always #5 CLK1 = ~CLK1;

  int cyc = 0;
  always @(posedge CLK1) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- core model ----------------
  int            core_delay = 0;   // 0 = never answers
  int            core_cnt   = 0;
  int            stray_req  = 0;
  int            stray_done = 0;
  logic [WW-1:0] pm_val = '0;
  logic [WW-1:0] am_val = '0;

  initial begin
    bus.core_ready = 1'b0;
    bus.core_pm    = '0;
    bus.core_am    = '0;
    forever begin
      @(posedge CLK1);
      #1;
      bus.core_ready = 1'b0;
      if (!RST_n) begin
        core_cnt = 0;
      end else begin
        if (core_cnt > 0) begin
          core_cnt--;
          if (core_cnt == 0) begin
            bus.core_ready = 1'b1;
            bus.core_pm    = pm_val;
            bus.core_am    = am_val;
          end
        end
        if (bus.core_enable && core_delay > 0) core_cnt = core_delay;
      end
      if (stray_req != stray_done) begin
        bus.core_ready = 1'b1;
        stray_done     = stray_req;
      end
    end
  end

  // ---------------- transaction-level model and compare ----------------
  int              m_ptr, m_id, m_start, pick;
  bit              m_job, m_resp, m_err, m_idle_prev;
  logic [WW-1:0]   m_i, m_q, m_pm, m_am, p_pm, p_am;
  logic [N-1:0]    p_req, exp_gnt, tmp;
  logic [N*WW-1:0] p_i, p_q;
  logic            p_ready, p_rsp_ready;

  always @(negedge CLK1) begin
    if (!RST_n) begin
      m_job = 0; m_resp = 0; m_idle_prev = 1; m_ptr = 0;
      p_req = '0; p_ready = 1'b0; p_rsp_ready = 1'b0;
    end else begin
      exp_gnt = '0;
      pick    = -1;
      if (m_idle_prev && p_req != '0) begin
        for (int k = 0; k < N; k++) begin
          tmp = p_req >> ((m_ptr + k) % N);
          if (pick < 0 && tmp[0]) pick = (m_ptr + k) % N;
        end
        exp_gnt = N'(1) << pick;
        m_job = 1; m_resp = 0; m_start = cyc; m_id = pick;
        m_ptr = (pick + 1) % N;
        m_i = WW'(p_i >> (pick * WW));
        m_q = WW'(p_q >> (pick * WW));
      end else if (m_job && !m_resp) begin
        if (p_ready && (cyc - 1) > m_start) begin
          m_resp = 1; m_err = 0; m_pm = p_pm; m_am = p_am;
        end else if ((cyc - 1) == m_start + TO) begin
          m_resp = 1; m_err = 1; m_pm = '0; m_am = '0;
        end
      end else if (m_job && m_resp && p_rsp_ready) begin
        m_job = 0; m_resp = 0;
      end

      chk("gnt", 32'(bus.gnt), 32'(exp_gnt));
      chk("core_enable", 32'(bus.core_enable), 32'(exp_gnt != '0));
      chk("busy", 32'(bus.busy), 32'(m_job));
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_job && m_resp));
      if (m_job) begin
        chk("core_i", 32'(bus.core_i), 32'(m_i));
        chk("core_q", 32'(bus.core_q), 32'(m_q));
      end
      if (m_job && m_resp) begin
        chk("rsp_id", 32'(bus.rsp_id), 32'(m_id));
        chk("rsp_pm", 32'(bus.rsp_pm), 32'(m_pm));
        chk("rsp_am", 32'(bus.rsp_am), 32'(m_am));
        chk("rsp_err", 32'(bus.rsp_err), 32'(m_err));
      end

      m_idle_prev = !m_job;
      p_req       = bus.req;
      p_i         = bus.req_i;
      p_q         = bus.req_q;
      p_ready     = bus.core_ready;
      p_pm        = bus.core_pm;
      p_am        = bus.core_am;
      p_rsp_ready = bus.rsp_ready;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge CLK1);
    #1;
  endtask

  task automatic wait_gnt(input int maxc, output int at);
    at = -1;
    for (int k = 0; k < maxc && at < 0; k++) begin
      @(negedge CLK1);
      if (bus.gnt != '0) at = cyc;
    end
    chk("gnt_seen", 32'(at >= 0), 32'd1);
  endtask

  task automatic wait_rsp(input int maxc, output int at);
    at = -1;
    for (int k = 0; k < maxc && at < 0; k++) begin
      @(negedge CLK1);
      if (bus.rsp_valid) at = cyc;
    end
    chk("rsp_seen", 32'(at >= 0), 32'd1);
  endtask

  task automatic wait_idle(input int maxc);
    bit seen;
    seen = 0;
    for (int k = 0; k < maxc && !seen; k++) begin
      @(negedge CLK1);
      if (!bus.busy) seen = 1;
    end
    chk("idle_seen", 32'(seen), 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_gnt"}, 32'(bus.gnt), 32'd0);
    chk({tag, "_core_enable"}, 32'(bus.core_enable), 32'd0);
    chk({tag, "_core_i"}, 32'(bus.core_i), 32'd0);
    chk({tag, "_core_q"}, 32'(bus.core_q), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, "_rsp_id"}, 32'(bus.rsp_id), 32'd0);
    chk({tag, "_rsp_pm"}, 32'(bus.rsp_pm), 32'd0);
    chk({tag, "_rsp_am"}, 32'(bus.rsp_am), 32'd0);
    chk({tag, "_rsp_err"}, 32'(bus.rsp_err), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
  endtask

  int g, r, x, prev_g;
  int          exp_order[6] = '{0, 1, 2, 3, 0, 1};
  logic [12:0] fair_i[4]    = '{13'h111, 13'h222, 13'h333, 13'h444};

  initial begin
    bus.req = '0; bus.req_i = '0; bus.req_q = '0; bus.rsp_ready = 1'b0;
    repeat (3) @(negedge CLK1);
    chk_reset_vals("reset");
    step();
    RST_n = 1'b1;

    // Single request, core answers 13 cycles after enable.
    step();
    bus.req_i[0 +: WW] = 13'h0100;
    bus.req_q[0 +: WW] = 13'h0080;
    pm_val = 13'h0123; am_val = 13'h0456; core_delay = 13; bus.rsp_ready = 1'b1;
    bus.req = 4'b0001;
    wait_gnt(5, g);
    chk("single_gnt", 32'(bus.gnt), 32'h1);
    chk("single_enable", 32'(bus.core_enable), 32'h1);
    chk("single_core_i", 32'(bus.core_i), 32'h100);
    chk("single_core_q", 32'(bus.core_q), 32'h080);
    @(negedge CLK1);
    chk("single_gnt_pulse", 32'(bus.gnt), 32'h0);
    step();
    bus.req = '0;
    wait_rsp(40, r);
    chk("single_latency", 32'(r - g), 32'd14);
    chk("single_id", 32'(bus.rsp_id), 32'd0);
    chk("single_pm", 32'(bus.rsp_pm), 32'h123);
    chk("single_am", 32'(bus.rsp_am), 32'h456);
    chk("single_err", 32'(bus.rsp_err), 32'd0);
    wait_idle(5);

    // Fairness from a fresh reset: pointer restarts at requester 0.
    step();
    RST_n = 1'b0;
    step();
    RST_n = 1'b1;
    for (int k = 0; k < N; k++) begin
      bus.req_i[k*WW +: WW] = fair_i[k];
      bus.req_q[k*WW +: WW] = 13'h0A0 + 13'(k);
    end
    core_delay = 2; pm_val = 13'h0777; am_val = 13'h0333;
    bus.req = 4'b1111;
    prev_g = 0;
    for (int k = 0; k < 6; k++) begin
      wait_gnt(10, g);
      chk("fair_order", 32'(bus.gnt), 32'(4'b0001 << exp_order[k]));
      chk("fair_core_i", 32'(bus.core_i), 32'(fair_i[exp_order[k]]));
      if (k > 0) chk("fair_period", 32'(g - prev_g), 32'd5);
      prev_g = g;
    end
    step();
    bus.req = '0;
    wait_idle(10);

    // Minimum job period with an immediately ready core.
    core_delay = 1;
    step();
    bus.req = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      wait_gnt(10, g);
      chk("minper_gnt", 32'(bus.gnt), 32'b0100);
      if (k > 0) chk("minper_period", 32'(g - prev_g), 32'd4);
      prev_g = g;
    end
    step();
    bus.req = '0;
    wait_idle(10);

    // Timeout: core never answers.
    core_delay = 0;
    step();
    bus.req = 4'b0001;
    wait_gnt(5, g);
    step();
    bus.req = '0;
    wait_rsp(100, r);
    chk("to_latency", 32'(r - g), 32'd64);
    chk("to_err", 32'(bus.rsp_err), 32'd1);
    chk("to_pm", 32'(bus.rsp_pm), 32'd0);
    chk("to_am", 32'(bus.rsp_am), 32'd0);
    chk("to_id", 32'(bus.rsp_id), 32'd0);
    wait_idle(5);

    // Next request after a timeout is served normally.
    core_delay = 3; pm_val = 13'h00AA; am_val = 13'h0055;
    step();
    bus.req = 4'b1000;
    wait_gnt(5, g);
    chk("after_to_gnt", 32'(bus.gnt), 32'b1000);
    step();
    bus.req = '0;
    wait_rsp(20, r);
    chk("after_to_latency", 32'(r - g), 32'd4);
    chk("after_to_err", 32'(bus.rsp_err), 32'd0);
    chk("after_to_pm", 32'(bus.rsp_pm), 32'h0AA);
    chk("after_to_id", 32'(bus.rsp_id), 32'd3);
    wait_idle(5);

    // Ready on exactly the timeout cycle: result wins.
    core_delay = 63; pm_val = 13'h03C3; am_val = 13'h01E1;
    step();
    bus.req = 4'b0010;
    wait_gnt(5, g);
    step();
    bus.req = '0;
    wait_rsp(100, r);
    chk("coll_latency", 32'(r - g), 32'd64);
    chk("coll_err", 32'(bus.rsp_err), 32'd0);
    chk("coll_pm", 32'(bus.rsp_pm), 32'h3C3);
    chk("coll_am", 32'(bus.rsp_am), 32'h1E1);
    wait_idle(5);

    // Stray ready while idle.
    step();
    stray_req++;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK1);
      chk("stray_idle_busy", 32'(bus.busy), 32'd0);
      chk("stray_idle_valid", 32'(bus.rsp_valid), 32'd0);
    end

    // Backpressure with a pending requester and a stray ready in RESP.
    core_delay = 2; pm_val = 13'h00F0; am_val = 13'h000F;
    bus.rsp_ready = 1'b0;
    step();
    bus.req = 4'b0001;
    wait_gnt(5, g);
    step();
    bus.req = '0;
    wait_rsp(20, r);
    step();
    bus.req = 4'b0010;
    pm_val = 13'h1555; am_val = 13'h0AAA;
    stray_req++;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK1);
      chk("bp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_pm", 32'(bus.rsp_pm), 32'h0F0);
      chk("bp_am", 32'(bus.rsp_am), 32'h00F);
      chk("bp_id", 32'(bus.rsp_id), 32'd0);
      chk("bp_gnt", 32'(bus.gnt), 32'd0);
    end
    step();
    bus.rsp_ready = 1'b1;
    x = cyc;
    wait_gnt(5, g);
    chk("bp_gnt_delay", 32'(g - x), 32'd2);
    chk("bp_gnt_id", 32'(bus.gnt), 32'b0010);
    step();
    bus.req = '0;
    wait_idle(10);

    // Reset in the middle of WAIT.
    core_delay = 0;
    step();
    bus.req = 4'b0100;
    wait_gnt(5, g);
    step();
    step();
    #2;
    RST_n = 1'b0;
    #1;
    chk_reset_vals("midreset");
    @(posedge CLK1);
    #1;
    RST_n = 1'b1;
    core_delay = 2;
    bus.req = 4'b1111;
    wait_gnt(5, g);
    chk("post_reset_gnt", 32'(bus.gnt), 32'b0001);
    step();
    bus.req = '0;
    wait_idle(10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d errors so far", n_errors);
    $fatal(1);
  end

endmodule
